// File: rtl/f_loader_pkg.sv
// f_loader_pkg: shared loader state type and default vector geometry.
package f_loader_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SIZE = 64;
    localparam int DEF_LOGSIZE = 6;
    typedef enum logic [1:0] {LOAD, SETTLE, FULL} loader_state_t;
endpackage

// File: rtl/f_loader_addr_counter.sv
// addr_counter: clearable write-address counter that wraps to 0 after MAX.
module addr_counter #(
    parameter int LOGSIZE = 6,
    parameter int MAX = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [LOGSIZE-1:0] count
);
    always_ff @(posedge clk)
        if (reset || clr) count <= '0;
        else if (inc) count <= (count == LOGSIZE'(MAX)) ? '0 : count + 1'b1;
endmodule

// File: rtl/f_loader.sv
// f_loader: streams one vector of coefficient words into the filter memory, then holds it until consumed.
module f_loader import f_loader_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE = DEF_SIZE,
    parameter int LOGSIZE = DEF_LOGSIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [WIDTH-1:0]  s_data_in,
    input  logic                     s_valid_in,
    output logic                     s_ready_out,
    output logic signed [WIDTH-1:0]  mem_data_out,
    output logic [LOGSIZE-1:0]       mem_addr_out,
    output logic                     mem_wr_en_out,
    output logic                     vec_valid_out,
    input  logic                     vec_consume_in
);
    loader_state_t state, state_next;
    logic last;
    logic clr;
    always_ff @(posedge clk)
        state <= reset ? LOAD : state_next;
    // SETTLE covers the memory's one-cycle registered parallel-output latency
    always_comb begin
        s_ready_out = state == LOAD && !reset;
        mem_wr_en_out = s_valid_in && s_ready_out;
        vec_valid_out = state == FULL && !reset;
        clr = state != LOAD;
        last = mem_wr_en_out && mem_addr_out == LOGSIZE'(SIZE - 1);
        state_next = (state == LOAD && last) ? SETTLE :
                     (state == SETTLE) ? FULL :
                     (state == FULL && vec_consume_in) ? LOAD : state;
    end
    assign mem_data_out = s_data_in;
    addr_counter #(.LOGSIZE(LOGSIZE), .MAX(SIZE - 1)) u_cnt (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .inc(mem_wr_en_out),
        .count(mem_addr_out)
    );
endmodule

// File: tb/tb_f_loader.sv
// tb_f_loader: drives a SIZE=4 and a SIZE=64 loader in lockstep against a word-count reference model.
module tb_f_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic v = 1'b0;
    logic c = 1'b0;
    logic signed [15:0] d = '0;
    logic r4, w4, vv4, r64, w64, vv64;
    logic [1:0] a4;
    logic [5:0] a64;
    logic signed [15:0] md4, md64;
    logic s_r4, s_w4, s_vv4, s_w64, s_vv64;
    int s_a4;
    int tests = 0;
    int fails = 0;
    int loaded[2] = '{0, 0};
    int age[2] = '{0, 0};
    logic signed [15:0] mem4[4];
    logic signed [15:0] par4[4];

    always #5 clk = ~clk;

    f_loader #(.WIDTH(16), .SIZE(4), .LOGSIZE(2)) u4 (
        .clk(clk), .reset(reset), .s_data_in(d), .s_valid_in(v), .s_ready_out(r4),
        .mem_data_out(md4), .mem_addr_out(a4), .mem_wr_en_out(w4),
        .vec_valid_out(vv4), .vec_consume_in(c)
    );
    f_loader u64 (
        .clk(clk), .reset(reset), .s_data_in(d), .s_valid_in(v), .s_ready_out(r64),
        .mem_data_out(md64), .mem_addr_out(a64), .mem_wr_en_out(w64),
        .vec_valid_out(vv64), .vec_consume_in(c)
    );

    // filter memory stand-in with a registered parallel output
    always @(posedge clk) begin
        if (w4) mem4[a4] <= md4;
        par4 <= mem4;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vi, input logic ci, input logic ri, input int di);
        v = vi;
        c = ci;
        reset = ri;
        d = 16'(di);
        @(negedge clk);
        s_r4 = r4; s_w4 = w4; s_a4 = int'(a4); s_vv4 = vv4; s_w64 = w64; s_vv64 = vv64;
        for (int k = 0; k < 2; k++) begin
            int sz = k ? 64 : 4;
            logic er;
            er = !ri && loaded[k] < sz;
            chk($sformatf("s%0d ready", sz), k ? r64 : r4, er);
            chk($sformatf("s%0d wr_en", sz), k ? w64 : w4, er && vi);
            chk($sformatf("s%0d vec_valid", sz), k ? vv64 : vv4, !ri && age[k] == 2);
            if (!ri) chk($sformatf("s%0d addr", sz), k ? int'(a64) : int'(a4), loaded[k] % sz);
            if (k ? w64 : w4) chk($sformatf("s%0d data", sz), k ? int'(md64) : int'(md4), int'(d));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int sz = k ? 64 : 4;
            if (ri || (age[k] == 2 && ci)) begin
                loaded[k] = 0;
                age[k] = 0;
            end else if (age[k] > 0) age[k] = 2;
            else if (vi && loaded[k] < sz) begin
                loaded[k]++;
                if (loaded[k] == sz) age[k] = 1;
            end
        end
        #1;
    endtask

    typedef struct {
        logic v;
        logic c;
        int d;
        logic er;
        logic ew;
        int ea;
        logic evv;
    } vec_t;

    initial begin
        vec_t tv[6];
        int exp_par[4];
        int pat[7];
        int addrs[$];
        int nw, nv;
        tv[0] = '{1'b1, 1'b0, 10, 1'b1, 1'b1, 0, 1'b0};
        tv[1] = '{1'b1, 1'b0, -20, 1'b1, 1'b1, 1, 1'b0};
        tv[2] = '{1'b1, 1'b0, 30, 1'b1, 1'b1, 2, 1'b0};
        tv[3] = '{1'b1, 1'b0, -40, 1'b1, 1'b1, 3, 1'b0};
        tv[4] = '{1'b1, 1'b0, 99, 1'b0, 1'b0, 0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 99, 1'b0, 1'b0, 0, 1'b1};
        exp_par = '{10, -20, 30, -40};
        pat = '{1, 0, 0, 1, 1, 0, 1};

        cyc(1'b1, 1'b1, 1'b1, 5);
        chk("reset ready", s_r4, 0);
        chk("reset wr_en", s_w4, 0);
        chk("reset vec_valid", s_vv4, 0);
        cyc(1'b0, 1'b0, 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            cyc(tv[i].v, tv[i].c, 1'b0, tv[i].d);
            chk($sformatf("tbl%0d ready", i), s_r4, tv[i].er);
            chk($sformatf("tbl%0d wr_en", i), s_w4, tv[i].ew);
            chk($sformatf("tbl%0d addr", i), s_a4, tv[i].ea);
            chk($sformatf("tbl%0d vec_valid", i), s_vv4, tv[i].evv);
            if (tv[i].evv)
                for (int j = 0; j < 4; j++) chk($sformatf("par%0d", j), int'(par4[j]), exp_par[j]);
        end

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 99);
            chk("full ready", s_r4, 0);
            chk("full wr_en", s_w4, 0);
            chk("full vec_valid", s_vv4, 1);
        end
        cyc(1'b1, 1'b1, 1'b0, 99);
        chk("consume vec_valid", s_vv4, 1);
        cyc(1'b1, 1'b0, 1'b0, 5);
        chk("post-consume vec_valid", s_vv4, 0);
        chk("post-consume ready", s_r4, 1);
        chk("post-consume wr_en", s_w4, 1);
        chk("post-consume addr", s_a4, 0);

        cyc(1'b0, 1'b0, 1'b1, 0);
        nw = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(pat[i] != 0, 1'b0, 1'b0, 100 + i);
            if (s_w4) addrs.push_back(s_a4);
            else if (i > 0) chk("stall addr hold", s_a4, addrs.size());
            nw += int'(s_w4);
        end
        chk("stall write count", nw, 4);
        for (int i = 0; i < addrs.size(); i++) chk("stall addr", addrs[i], i);
        cyc(1'b0, 1'b0, 1'b0, 0);
        chk("stall settle vec_valid", s_vv4, 0);
        cyc(1'b0, 1'b0, 1'b0, 0);
        chk("stall full vec_valid", s_vv4, 1);

        cyc(1'b0, 1'b0, 1'b1, 0);
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b1, 1'b0, 1'b0, 2);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 3);
        chk("load-consume addr2", s_a4, 2);
        cyc(1'b1, 1'b0, 1'b0, 4);
        chk("load-consume addr3", s_a4, 3);
        cyc(1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0);
        chk("load-consume vec_valid", s_vv4, 1);
        cyc(1'b0, 1'b0, 1'b1, 0);
        chk("reset in full vec_valid", s_vv4, 0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 20 + i);
        cyc(1'b1, 1'b0, 1'b1, 7);
        chk("mid reset ready", s_r4, 0);
        chk("mid reset wr_en", s_w4, 0);
        cyc(1'b1, 1'b0, 1'b1, 7);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 30 + i);
            chk("fresh addr", s_a4, i);
            chk("fresh vec_valid", s_vv4, 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 0);
        chk("fresh settle vec_valid", s_vv4, 0);
        cyc(1'b0, 1'b0, 1'b0, 0);
        chk("fresh full vec_valid", s_vv4, 1);

        cyc(1'b0, 1'b0, 1'b1, 0);
        nw = 0;
        nv = 0;
        for (int i = 0; i < 198; i++) begin
            cyc(1'b1, 1'b1, 1'b0, int'($urandom));
            nw += int'(s_w64);
            nv += int'(s_vv64);
        end
        chk("s64 write count", nw, 192);
        chk("s64 vec_valid count", nv, 3);

        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 199) == 0, int'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
